fp_op_scheduler: RTL and testbench
==================================

Name: fp_op_scheduler

Overview:
- Shares the single floating-point add/multiply datapath (alignment, add, normalisation stages) between two requesters.
- Accepts one operation at a time via valid/ready and launches the datapath with a one-cycle start pulse.
- Waits for the datapath done pulse, then returns the result tagged with the requester id.
- Provides a watchdog so a datapath that never signals done cannot hang the system; the block sits directly above the datapath in the FP top level.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles in WAIT before aborting with error (>=2).
- CNT_W, 7, width of watchdog counter (must hold TIMEOUT_CYCLES).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  scheduler accepts requester 0 this cycle.
- req0_a, req0_b  input  32  IEEE-754 single operands.
- req0_op  input  1  0=add, 1=multiply.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0.
- dp_start  output  1  one-cycle launch pulse to datapath.
- dp_a, dp_b  output  32  registered operands to datapath, stable from start until done.
- dp_op  output  1  registered operation select.
- dp_done  input  1  datapath completion pulse.
- dp_result  input  32  datapath result, valid when dp_done=1.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  1  requester that issued the operation.
- rsp_data  output  32  result (0 on error).
- rsp_err  output  1  1 = watchdog timeout.

Behaviour:
- Reset: all outputs 0, state IDLE, watchdog counter 0, round-robin pointer favours requester 0.
- States and transitions:
  - IDLE: on accept, go to ISSUE.
  - ISSUE: always go to WAIT.
  - WAIT: on dp_done or timeout, go to RESP.
  - RESP: on rsp_ready, go to IDLE.
- Arbitration in IDLE is round-robin:
  - If only one valid, grant it.
  - If both valid, grant the one not served last.
  - reqN_ready = (state==IDLE) and granted N. It is combinational from state, pointer and valids; at most one ready is high per cycle.
  - Accept happens on valid and ready in the same cycle. Operands, op and id are latched at that edge and the pointer is updated.
- ISSUE: dp_start=1 for exactly one cycle; dp_a/dp_b/dp_op already hold the latched values.
- WAIT:
  - The counter increments each cycle.
  - dp_done=1 captures dp_result into rsp_data with rsp_err=0, then goes to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without dp_done: rsp_data=0, rsp_err=1, then RESP.
  - dp_done on the same cycle as timeout: dp_done wins, no error.
- RESP:
  - rsp_valid=1; rsp_id/data/err are held stable until rsp_ready=1.
  - On the handshake cycle, rsp_valid drops next cycle, the counter clears and the state returns to IDLE.
  - No new request is accepted in RESP (single outstanding op).
- dp_done in IDLE, ISSUE or RESP is ignored (stray pulse); it must not corrupt rsp_data.
- Latency:
  - Accept at edge T gives dp_start high in cycle T+1.
  - dp_done in cycle D gives rsp_valid high in cycle D+1.
  - Minimum accept-to-response is 3 cycles with a 1-cycle datapath.
- Back-to-back throughput: with rsp_ready tied high, the next accept can happen the cycle after the RESP handshake.
- Reset asserted mid-operation:
  - Immediate return to IDLE, outputs 0.
  - The in-flight op is dropped with no response.
  - dp_done after reset release is treated as stray.
- Requester valid dropping before grant is legal (no request is latched).

Decomposition:
- Shared package fp_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}.
  - FP_W=32.
  - OP_ADD=0, OP_MUL=1.
  - Canonical constants FP_ONE=0x3F800000, FP_TWO=0x40000000, FP_THREE=0x40400000 for benches.
- One natural sub-module: rr_arbiter2 (two-input round-robin grant with pointer update on accept).

Test Plan:
- Single add: req0 a=0x3F800000, b=0x40000000, op=0; model datapath pulses done with 0x40400000 after 5 cycles -> rsp_valid, id=0, data=0x40400000, err=0, exactly one dp_start.
- Contention: both valid every cycle for 4 ops -> grants alternate 0,1,0,1; rsp_id sequence matches; no cycle with both readies high.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp fields stable, req ready stays 0, no second dp_start.
- Timeout: datapath never pulses done, TIMEOUT_CYCLES=64 -> rsp_err=1, rsp_data=0 at WAIT entry+64 cycles; dp_done on the timeout cycle instead -> err=0, data captured.
- Stray done: pulse dp_done in IDLE and in RESP -> no state change, rsp_data unchanged.
- Reset mid-WAIT: assert reset asynchronously -> all outputs 0 immediately; next request serviced normally, with requester 0 favoured.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the FP operation scheduler and its benches.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fp_pkg;

    localparam int FP_W = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    // Canonical IEEE-754 single values used by directed tests.
    localparam logic [FP_W-1:0] FP_ONE   = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_TWO   = 32'h4000_0000;
    localparam logic [FP_W-1:0] FP_THREE = 32'h4040_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/fp_op_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter; the favoured side flips to the loser on each accept.
// Latency: grant is combinational from enable, valids and pointer; pointer updates on the accept edge.
// Backpressure: no grant while en is low; a requester that drops valid before grant is simply not granted.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1,
    output logic grant_id,
    output logic accept
);

    // prio = requester favoured when both are valid; 0 after reset.
    logic prio;

    // Grant the lone requester, or the favoured one under contention.
    always_comb begin
        grant0   = en & valid0 & (~valid1 | ~prio);
        grant1   = en & valid1 & (~valid0 |  prio);
        grant_id = grant1;
        accept   = grant0 | grant1;
    end

    // After serving a requester, favour the other one next time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (accept) begin
            prio <= ~grant_id;
        end
    end

endmodule

// File: rtl/fp_op_scheduler.sv
// Shares one FP add/mul datapath between two requesters, one op in flight, with a watchdog on done.
// Latency: accept at T -> dp_start in T+1; dp_done in D -> rsp_valid in D+1 (3 cycles min with 1-cycle datapath).
// Backpressure: rsp fields hold until rsp_ready; no request is accepted outside IDLE.
module fp_op_scheduler
    import fp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [FP_W-1:0] req0_a,
    input  logic [FP_W-1:0] req0_b,
    input  logic            req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [FP_W-1:0] req1_a,
    input  logic [FP_W-1:0] req1_b,
    input  logic            req1_op,
    output logic            dp_start,
    output logic [FP_W-1:0] dp_a,
    output logic [FP_W-1:0] dp_b,
    output logic            dp_op,
    input  logic            dp_done,
    input  logic [FP_W-1:0] dp_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [FP_W-1:0] rsp_data,
    output logic            rsp_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic            op_id;
    logic            arb_en;
    logic            grant0;
    logic            grant1;
    logic            grant_id;
    logic            accept;

    // Readies are forced low while reset is held so outputs read 0 immediately.
    always_comb begin
        arb_en     = (state == IDLE) & ~reset;
        req0_ready = grant0;
        req1_ready = grant1;
    end

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .en       (arb_en),
        .valid0   (req0_valid),
        .valid1   (req1_valid),
        .grant0   (grant0),
        .grant1   (grant1),
        .grant_id (grant_id),
        .accept   (accept)
    );

    // Control FSM, operand latch, watchdog and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_id     <= 1'b0;
            dp_start  <= 1'b0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_op     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dp_a     <= grant_id ? req1_a  : req0_a;
                        dp_b     <= grant_id ? req1_b  : req0_b;
                        dp_op    <= grant_id ? req1_op : req0_op;
                        op_id    <= grant_id;
                        dp_start <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    dp_start <= 1'b0;
                    cnt      <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the timeout cycle still counts as success.
                    if (dp_done) begin
                        rsp_data  <= dp_result;
                        rsp_err   <= 1'b0;
                        rsp_id    <= op_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_id    <= op_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_op_scheduler.sv
// Directed bench for fp_op_scheduler: table of single ops plus contention, backpressure, stray-done and reset sequences.
// Latency: checks accept->start and WAIT-entry->response cycle counts.
// Backpressure: exercises rsp_ready held low while requests wait.
module tb_fp_op_scheduler;
    import fp_pkg::*;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_op;
    logic [31:0] req1_a, req1_b;
    logic        dp_start, dp_op, dp_done;
    logic [31:0] dp_a, dp_b, dp_result;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_data;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;
    int both_rdy = 0;

    fp_op_scheduler #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op),
        .dp_done(dp_done), .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count launch pulses and any cycle with both readies high.
    always @(negedge clk) begin
        if (dp_start) start_cnt++;
        if (req0_ready && req1_ready) both_rdy++;
    end

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        int          done_after;
        logic        give_done;
        logic [31:0] res;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present one op on requester id, play the datapath, return the response seen.
    task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b, input logic op,
                         input int done_after, input logic give_done, input logic [31:0] res,
                         output logic got_id, output logic [31:0] got_data, output logic got_err,
                         output int lat, output int starts);
        int  s0;
        bit  ok;
        s0 = start_cnt;
        ok = 0;
        lat = 0;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
        for (int k = 0; k < 20; k++) begin
            #1;
            if (id ? req1_ready : req0_ready) begin ok = 1; break; end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL accept_wait: got no ready expected ready within 20 cycles");
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("issue_start", {dp_start, dp_op, dp_a, dp_b}, {1'b1, op, a, b});
        step();
        if (give_done) begin
            repeat (done_after) begin step(); lat++; end
            dp_done = 1'b1; dp_result = res;
            step(); lat++;
            dp_done = 1'b0; dp_result = 32'hDEAD_BEEF;
        end
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (rsp_valid) begin ok = 1; break; end
            step(); lat++;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL rsp_wait: got no rsp_valid expected rsp_valid within 200 cycles");
        end
        got_id = rsp_id; got_data = rsp_data; got_err = rsp_err;
        starts = start_cnt - s0;
        if (rsp_ready) step();
    endtask

    logic        g_id, g_err;
    logic [31:0] g_data;
    int          g_lat, g_starts, s_base, bad;

    initial begin
        reset = 1'b1; rsp_ready = 1'b1; dp_done = 1'b0; dp_result = '0;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = 0;

        vecs[0] = '{1'b0, FP_ONE,   FP_TWO,   OP_ADD, 5,  1'b1, FP_THREE,     FP_THREE,     1'b0, 6};
        vecs[1] = '{1'b1, FP_TWO,   FP_THREE, OP_MUL, 0,  1'b1, 32'h40C00000, 32'h40C00000, 1'b0, 1};
        vecs[2] = '{1'b0, FP_THREE, FP_ONE,   OP_ADD, 63, 1'b1, 32'h40800000, 32'h40800000, 1'b0, 64};
        vecs[3] = '{1'b1, FP_ONE,   FP_ONE,   OP_MUL, 0,  1'b0, 32'h12345678, 32'h00000000, 1'b1, 64};
        vecs[4] = '{1'b0, FP_TWO,   FP_TWO,   OP_ADD, 1,  1'b1, 32'h40800000, 32'h40800000, 1'b0, 2};

        // Reset state, including readies gated while reset is high.
        step(); step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("reset_outputs", {req0_ready, req1_ready, dp_start, dp_op, dp_a, dp_b, rsp_valid, rsp_id, rsp_err, rsp_data}, '0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        reset = 1'b0;
        step();

        // Contention: both valid continuously, grants must alternate from requester 0.
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = FP_ONE; req0_b = FP_ONE; req1_a = FP_TWO; req1_b = FP_TWO;
        for (int i = 0; i < 4; i++) begin
            logic g;
            bit   ok;
            ok = 0; g = 1'b0;
            for (int k = 0; k < 20; k++) begin
                #1;
                if (req0_ready || req1_ready) begin ok = 1; g = req1_ready; break; end
                @(posedge clk); #1;
            end
            if (!ok) begin
                tests++; fails++;
                $display("FAIL cont_accept: got no ready expected ready in op %0d", i);
            end
            check($sformatf("cont_grant%0d", i), g, (i % 2));
            step();
            step();
            dp_done = 1'b1; dp_result = 32'h3F800000 + i;
            step();
            dp_done = 1'b0;
            check($sformatf("cont_rsp%0d", i), {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'((i % 2)), 32'h3F800000 + i});
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Table of single ops: normal, 1-cycle datapath, done on timeout cycle, timeout.
        for (int v = 0; v < 5; v++) begin
            do_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].done_after, vecs[v].give_done,
                  vecs[v].res, g_id, g_data, g_err, g_lat, g_starts);
            check($sformatf("vec%0d_rsp", v), {g_id, g_data, g_err}, {vecs[v].id, vecs[v].exp_data, vecs[v].exp_err});
            check($sformatf("vec%0d_lat", v), g_lat, vecs[v].exp_lat);
            check($sformatf("vec%0d_starts", v), g_starts, 1);
            check($sformatf("vec%0d_drop", v), rsp_valid, 1'b0);
            step();
        end

        // Backpressure with a stray done in RESP.
        rsp_ready = 1'b0;
        do_op(1'b0, FP_ONE, FP_THREE, OP_ADD, 3, 1'b1, 32'h40800000, g_id, g_data, g_err, g_lat, g_starts);
        check("bp_rsp", {g_id, g_data, g_err}, {1'b0, 32'h40800000, 1'b0});
        req1_valid = 1'b1; req1_a = FP_TWO; req1_b = FP_TWO;
        s_base = start_cnt;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            dp_done = (c == 4); dp_result = 32'hDEAD_BEEF;
            step();
            if (!rsp_valid || rsp_id !== 1'b0 || rsp_data !== 32'h40800000 || rsp_err !== 1'b0 || req0_ready || req1_ready)
                bad++;
        end
        dp_done = 1'b0;
        check("bp_stable", bad, 0);
        check("bp_no_start", start_cnt - s_base, 0);
        rsp_ready = 1'b1;
        step();
        check("bp_release", {rsp_valid, req1_ready}, 2'b01);
        req1_valid = 1'b0;
        step();

        // Stray done in IDLE must not touch the response.
        dp_done = 1'b1; dp_result = 32'hBAD0_BAD0;
        step();
        dp_done = 1'b0;
        step();
        check("stray_idle", {rsp_valid, dp_start, rsp_data}, {1'b0, 1'b0, 32'h40800000});

        // Reset asserted mid-WAIT drops the op; requester 0 is favoured afterwards.
        req0_valid = 1'b1; req0_a = FP_TWO; req0_b = FP_THREE; req0_op = OP_MUL;
        #1;
        check("rst_pre_accept", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        step(); step(); step();
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_outputs", {dp_start, dp_op, dp_a, dp_b, rsp_valid, rsp_id, rsp_err, rsp_data}, '0);
        step();
        reset = 1'b0;
        step();
        dp_done = 1'b1; dp_result = 32'hBAD1_BAD1;
        step();
        dp_done = 1'b0;
        step();
        check("rst_stray", {rsp_valid, rsp_data}, {1'b0, 32'h0});
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst_favour0", {req0_ready, req1_ready}, 2'b10);
        req1_valid = 1'b0;
        do_op(1'b0, FP_TWO, FP_THREE, OP_MUL, 2, 1'b1, 32'h40C00000, g_id, g_data, g_err, g_lat, g_starts);
        check("rst_next_op", {g_id, g_data, g_err, g_starts[3:0]}, {1'b0, 32'h40C00000, 1'b0, 4'd1});
        step();

        check("never_both_ready", both_rdy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
